// File: rtl/pc_sequencer.sv
// Program-counter sequencing FSM: boot, fetch handshake, next-PC selection and halt/interrupt handling.
// Optional macro PCSEQ_EPC_EN adds an exception PC register (epc) and a return-from-interrupt input (reti).
module pc_sequencer #(
  parameter logic [15:0] RESET_VEC = 16'h0000,
  parameter logic [15:0] IRQ_VEC   = 16'h00F0,
  parameter int unsigned INC       = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] pc_cnt,
  output logic        pc_wr,
  output logic [15:0] pc_next,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic        imem_ack,
  input  logic        dec_valid,
  input  logic        stall,
  input  logic        br_taken,
  input  logic [15:0] br_tgt,
  input  logic        jmp,
  input  logic [15:0] jmp_tgt,
  input  logic        halt_req,
  input  logic        irq,
`ifdef PCSEQ_EPC_EN
  input  logic        reti,
  output logic [15:0] epc,
`endif
  output logic        halted,
  output logic [15:0] retired_cnt
);

  typedef enum logic [2:0] {
    BOOT   = 3'd0,
    FETCH  = 3'd1,
    DECODE = 3'd2,
    UPDATE = 3'd3,
    HALT   = 3'd4
  } state_t;

  state_t      state, state_n;
  logic        in_rst;
  logic        hlt_flag, hlt_flag_n;
  logic [15:0] nxt, nxt_n;
  logic [15:0] plain_tgt;
  logic        boot_wr;

  function automatic logic [15:0] pc_inc(input logic [15:0] pc);
    pc_inc = pc + 16'(INC);
  endfunction

`ifdef PCSEQ_EPC_EN
  logic [15:0] epc_n;
  always_comb begin
    plain_tgt = reti     ? epc     :
                jmp      ? jmp_tgt :
                br_taken ? br_tgt  : pc_inc(pc_cnt);
  end
`else
  always_comb begin
    plain_tgt = jmp      ? jmp_tgt :
                br_taken ? br_tgt  : pc_inc(pc_cnt);
  end
`endif

  always_comb begin
    state_n    = state;
    nxt_n      = nxt;
    hlt_flag_n = hlt_flag;
`ifdef PCSEQ_EPC_EN
    epc_n      = epc;
`endif
    case (state)
      // BOOT is held while reset is still being observed, so the write pulse follows release
      BOOT:   if (!in_rst) state_n = FETCH;
      FETCH:  if (imem_ack) state_n = DECODE;
      DECODE: begin
        if (dec_valid && !stall) begin
          state_n    = UPDATE;
          hlt_flag_n = halt_req && !irq;
          if (irq) begin
            nxt_n = IRQ_VEC;
`ifdef PCSEQ_EPC_EN
            epc_n = plain_tgt;
`endif
          end else begin
            nxt_n = plain_tgt;
          end
        end
      end
      UPDATE: state_n = hlt_flag ? HALT : FETCH;
      HALT: begin
        if (irq) begin
          state_n    = UPDATE;
          nxt_n      = IRQ_VEC;
          hlt_flag_n = 1'b0;
`ifdef PCSEQ_EPC_EN
          epc_n      = pc_cnt;
`endif
        end
      end
      default: state_n = BOOT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= BOOT;
      in_rst      <= 1'b1;
      hlt_flag    <= 1'b0;
      retired_cnt <= 16'h0000;
`ifdef PCSEQ_EPC_EN
      epc         <= 16'h0000;
`endif
    end else begin
      state    <= state_n;
      in_rst   <= 1'b0;
      hlt_flag <= hlt_flag_n;
      if (state == UPDATE) retired_cnt <= retired_cnt + 16'd1;
`ifdef PCSEQ_EPC_EN
      epc      <= epc_n;
`endif
    end
  end

  always_ff @(posedge clk) begin
    nxt <= nxt_n;
  end

  // Moore output decode; the only pass-through is the fetch address
  assign boot_wr   = (state == BOOT) && !in_rst;
  assign pc_wr     = boot_wr || (state == UPDATE);
  assign pc_next   = (state == UPDATE) ? nxt : (boot_wr ? RESET_VEC : 16'h0000);
  assign imem_req  = (state == FETCH);
  assign imem_addr = pc_cnt;
  assign halted    = (state == HALT);

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: table of single-instruction vectors plus hand sequences
// for boot, free-running throughput, halt/interrupt resume and reset during fetch.
module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] pc_cnt;
  logic        pc_wr;
  logic [15:0] pc_next;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_ack;
  logic        dec_valid;
  logic        stall;
  logic        br_taken;
  logic [15:0] br_tgt;
  logic        jmp;
  logic [15:0] jmp_tgt;
  logic        halt_req;
  logic        irq;
  logic        halted;
  logic [15:0] retired_cnt;
`ifdef PCSEQ_EPC_EN
  logic        reti;
  logic [15:0] epc;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  pc_sequencer dut (
    .clk(clk), .rst(rst), .pc_cnt(pc_cnt), .pc_wr(pc_wr), .pc_next(pc_next),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
    .dec_valid(dec_valid), .stall(stall), .br_taken(br_taken), .br_tgt(br_tgt),
    .jmp(jmp), .jmp_tgt(jmp_tgt), .halt_req(halt_req), .irq(irq),
`ifdef PCSEQ_EPC_EN
    .reti(reti), .epc(epc),
`endif
    .halted(halted), .retired_cnt(retired_cnt)
  );

  typedef struct {
    logic [15:0] pc;
    logic        jmp;
    logic [15:0] jt;
    logic        br;
    logic [15:0] bt;
    logic        irq;
    logic        hlt;
    int          stl;
    int          dly;
    logic [15:0] exp_nxt;
    logic        exp_hlt;
  } vec_t;

  vec_t vecs [7];
  logic [15:0] exp_ret;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  // Starts at a negedge in FETCH; ends at the negedge after the UPDATE cycle.
  task automatic run_vec(input int i);
    int req_cnt;
    vec_t v;
    v = vecs[i];
    pc_cnt = v.pc; jmp = v.jmp; jmp_tgt = v.jt; br_taken = v.br; br_tgt = v.bt;
    irq = v.irq; halt_req = v.hlt; stall = (v.stl > 0); dec_valid = 1'b1;
    chk($sformatf("v%0d imem_addr", i), imem_addr, v.pc);
    req_cnt = 0;
    for (int k = 0; k <= v.dly; k++) begin
      if (imem_req === 1'b1) req_cnt++;
      imem_ack = (k == v.dly);
      step();
    end
    imem_ack = 1'b0;
    chk($sformatf("v%0d req_cycles", i), 16'(req_cnt), 16'(v.dly + 1));
    for (int s = 0; s < v.stl; s++) begin
      chk($sformatf("v%0d stall_pc_wr", i), {15'd0, pc_wr}, 16'd0);
      step();
    end
    stall = 1'b0;
    step();
    chk($sformatf("v%0d pc_wr", i), {15'd0, pc_wr}, 16'd1);
    chk($sformatf("v%0d pc_next", i), pc_next, v.exp_nxt);
    irq = 1'b0; halt_req = 1'b0; jmp = 1'b0; br_taken = 1'b0;
    step();
    exp_ret = exp_ret + 16'd1;
    chk($sformatf("v%0d retired", i), retired_cnt, exp_ret);
    chk($sformatf("v%0d halted", i), {15'd0, halted}, {15'd0, v.exp_hlt});
    chk($sformatf("v%0d imem_req", i), {15'd0, imem_req}, {15'd0, ~v.exp_hlt});
  endtask

  initial begin
    int wr_cnt;
    //            pc       jmp   jt       br    bt       irq   hlt   stl dly  exp      halt
    vecs[0] = '{16'h0010, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0, 0, 0, 16'h0012, 1'b0};
    vecs[1] = '{16'hFFFE, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0, 0, 4, 16'h0000, 1'b0};
    vecs[2] = '{16'h0030, 1'b1, 16'h0200, 1'b1, 16'h0100, 1'b0, 1'b0, 3, 0, 16'h0200, 1'b0};
    vecs[3] = '{16'h0050, 1'b0, 16'h0000, 1'b1, 16'h0100, 1'b0, 1'b0, 0, 1, 16'h0100, 1'b0};
    vecs[4] = '{16'h0060, 1'b1, 16'h0300, 1'b0, 16'h0000, 1'b1, 1'b0, 0, 0, 16'h00F0, 1'b0};
    vecs[5] = '{16'h0070, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1, 1'b1, 0, 0, 16'h00F0, 1'b0};
    vecs[6] = '{16'h0040, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b1, 0, 0, 16'h0042, 1'b1};

    rst = 1'b1; pc_cnt = 16'h0000; imem_ack = 1'b0; dec_valid = 1'b0; stall = 1'b0;
    br_taken = 1'b0; br_tgt = 16'h0000; jmp = 1'b0; jmp_tgt = 16'h0000;
    halt_req = 1'b0; irq = 1'b0;
`ifdef PCSEQ_EPC_EN
    reti = 1'b0;
`endif
    exp_ret = 16'h0000;

    // reset held for two edges, then boot pulse, then fetch
    step(); step();
    chk("rst pc_wr", {15'd0, pc_wr}, 16'd0);
    chk("rst pc_next", pc_next, 16'h0000);
    chk("rst imem_req", {15'd0, imem_req}, 16'd0);
    chk("rst halted", {15'd0, halted}, 16'd0);
    chk("rst retired", retired_cnt, 16'h0000);
    rst = 1'b0;
    step();
    chk("boot pc_wr", {15'd0, pc_wr}, 16'd1);
    chk("boot pc_next", pc_next, 16'h0000);
    chk("boot imem_req", {15'd0, imem_req}, 16'd0);
    step();
    chk("fetch imem_req", {15'd0, imem_req}, 16'd1);
    chk("fetch pc_wr", {15'd0, pc_wr}, 16'd0);
    chk("fetch retired", retired_cnt, 16'h0000);

    for (int i = 0; i < 7; i++) run_vec(i);

    // sitting in HALT: no writes, no fetches until irq
    for (int k = 0; k < 3; k++) begin
      chk("halt halted", {15'd0, halted}, 16'd1);
      chk("halt pc_wr", {15'd0, pc_wr}, 16'd0);
      chk("halt imem_req", {15'd0, imem_req}, 16'd0);
      step();
    end
    irq = 1'b1;
    step();
    chk("halt_irq pc_wr", {15'd0, pc_wr}, 16'd1);
    chk("halt_irq pc_next", pc_next, 16'h00F0);
    chk("halt_irq halted", {15'd0, halted}, 16'd0);
    irq = 1'b0;
    step();
    exp_ret = exp_ret + 16'd1;
    chk("halt_irq retired", retired_cnt, exp_ret);
    chk("resume imem_req", {15'd0, imem_req}, 16'd1);

    // free run with ack and valid tied high: one write every third cycle
    pc_cnt = 16'h0010; imem_ack = 1'b1; dec_valid = 1'b1;
    wr_cnt = 0;
    for (int k = 0; k < 9; k++) begin
      if (pc_wr === 1'b1) begin
        wr_cnt++;
        chk("run pc_next", pc_next, 16'h0012);
        chk("run phase", 16'(k % 3), 16'd2);
      end
      step();
    end
    chk("run writes", 16'(wr_cnt), 16'd3);
    exp_ret = exp_ret + 16'd3;
    chk("run retired", retired_cnt, exp_ret);
    imem_ack = 1'b0;
    chk("run refetch", {15'd0, imem_req}, 16'd1);

    // reset while fetching, with a late ack that must be ignored
    step();
    chk("mid fetch imem_req", {15'd0, imem_req}, 16'd1);
    rst = 1'b1;
    step();
    chk("mid rst imem_req", {15'd0, imem_req}, 16'd0);
    chk("mid rst retired", retired_cnt, 16'h0000);
    rst = 1'b0; imem_ack = 1'b1;
    step();
    chk("mid boot pc_wr", {15'd0, pc_wr}, 16'd1);
    chk("mid boot imem_req", {15'd0, imem_req}, 16'd0);
    imem_ack = 1'b0;
    step();
    chk("mid refetch imem_req", {15'd0, imem_req}, 16'd1);
    chk("mid refetch pc_wr", {15'd0, pc_wr}, 16'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Control FSM that sequences the 16-bit program counter register: drives its write enable and next-value bus, handshakes instruction fetch with instruction memory, and selects the next PC.
- Next-PC sources: sequential (PC+INC), branch target, jump target, interrupt vector.
- Sits between the PC register, instruction memory and the decode stage; the PC register's current count is fed back as `pc_cnt`.

Parameters:
- RESET_VEC, 16'h0000, PC value loaded in BOOT after reset.
- IRQ_VEC, 16'h00F0, PC value loaded when an interrupt is taken.
- INC, 2, sequential increment in bytes; must be 1..15.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- pc_cnt  in  16  current PC register value.
- pc_wr  out  1  write strobe to PC register.
- pc_next  out  16  value written to PC register when `pc_wr`=1.
- imem_req  out  1  fetch request; held until acknowledged.
- imem_addr  out  16  fetch address; equals `pc_cnt` while `imem_req`=1.
- imem_ack  in  1  fetch acknowledge.
- dec_valid  in  1  decode stage has resolved the fetched instruction.
- stall  in  1  hazard stall; blocks the PC update.
- br_taken  in  1  conditional branch taken.
- br_tgt  in  16  branch target address.
- jmp  in  1  unconditional jump.
- jmp_tgt  in  16  jump target address.
- halt_req  in  1  HALT instruction decoded.
- irq  in  1  level-sensitive interrupt request.
- halted  out  1  high while in HALT.
- retired_cnt  out  16  count of completed PC updates; wraps.

Behaviour:
- Reset: clk and rst are one clock domain; reset is synchronous, active-high. With `rst`=1 at a rising edge:
  - state <= BOOT;
  - `pc_wr`=0, `pc_next`=16'h0000, `imem_req`=0, `halted`=0, `retired_cnt`=0.
  - Reset mid-fetch drops `imem_req` at that edge; a late `imem_ack` is ignored.
- Outputs are registered or Moore-decoded from state; no combinational input-to-output paths except `imem_addr` = `pc_cnt`.
- BOOT:
  - 1 cycle: `pc_wr`=1, `pc_next`=RESET_VEC; `retired_cnt` not incremented.
  - Next state: FETCH.
- FETCH:
  - `imem_req`=1.
  - On `imem_ack`=1 -> DECODE; otherwise remain in FETCH indefinitely.
- DECODE: wait for `dec_valid`=1 and `stall`=0. When both hold, capture `nxt` by priority, then -> UPDATE:
  1. `irq` -> IRQ_VEC
  2. `jmp` -> `jmp_tgt`
  3. `br_taken` -> `br_tgt`
  4. otherwise -> (`pc_cnt` + INC) mod 2^16; 16'hFFFE+2 = 16'h0000.
  - Also capture `halt_req` into `hlt_flag`; `irq` clears `hlt_flag` (interrupt wins over halt).
  - `stall`=1 holds DECODE with nothing captured, even if `dec_valid`=1.
- UPDATE:
  - 1 cycle: `pc_wr`=1, `pc_next`=`nxt`, `retired_cnt` += 1 (wraps 16'hFFFF -> 0).
  - Next state: HALT if `hlt_flag`, else FETCH.
  - Halt still updates the PC (to `nxt`), so resume fetches past the HALT.
- HALT:
  - `halted`=1, `pc_wr`=0, `imem_req`=0.
  - `irq`=1 -> capture `nxt`=IRQ_VEC, clear `hlt_flag`, -> UPDATE.
  - Only rst or irq exit HALT.
- Minimum cycles per instruction: 3 (FETCH with same-cycle ack, DECODE, UPDATE).
- `pc_wr` is never asserted in FETCH, DECODE or HALT.
- Unused state encodings -> BOOT.

Optional Feature:
- Macro: PCSEQ_EPC_EN.
- Defined:
  - Adds output `epc` (16) and input `reti` (1).
  - On interrupt entry from DECODE, `epc` <= the `nxt` that would have been taken without the interrupt.
  - On interrupt entry from HALT, `epc` <= `pc_cnt`.
  - In DECODE, `reti`=1 selects `epc` as `nxt` at priority between `irq` and `jmp`.
  - `epc` resets to 16'h0000.
- Not defined: no `epc` register, no `reti` port; behaviour exactly as above.

Test Plan:
- Reset/boot: hold `rst` 2 cycles, release -> next cycle `pc_wr`=1, `pc_next`=16'h0000, then `imem_req`=1, `retired_cnt`=0.
- Sequential run: `imem_ack` and `dec_valid` tied high, `pc_cnt`=16'h0010 -> `pc_wr` pulse every 3rd cycle, `pc_next`=16'h0012, `retired_cnt`=1.
- Wrap and fetch wait: `pc_cnt`=16'hFFFE, `imem_ack` delayed 4 cycles -> `imem_req` held 5 cycles, then `pc_next`=16'h0000.
- Priority/stall: `jmp`=1 `jmp_tgt`=16'h0200, `br_taken`=1 `br_tgt`=16'h0100, `stall`=1 for 3 cycles -> no `pc_wr` during stall, then `pc_next`=16'h0200.
- Halt/irq: `halt_req`=1 at `pc_cnt`=16'h0040 -> `pc_next`=16'h0042, `halted`=1 with no further `pc_wr`/`imem_req`; `irq`=1 -> `pc_next`=16'h00F0, `halted`=0.
- Interrupt over halt and mid-op reset: `irq`=1 and `halt_req`=1 same DECODE -> `pc_next`=16'h00F0 with no HALT; `rst` during FETCH -> `imem_req`=0 at that edge, BOOT follows.
